// File: rtl/net_stream_arbiter.sv
// ============================================================================
// Module   : net_stream_arbiter
// Brief    : Round-robin merge of buffered GMII-style frame sources onto one
//            registered output stream, with inter-frame gap and frame watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module net_stream_arbiter #(
    parameter int N_PORTS        = 4,
    parameter int IFG_CYCLES     = 12,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input  logic                   gmii_clk_out,
    input  logic                   rst_n,
    input  logic [N_PORTS-1:0]     request,
    output logic [N_PORTS-1:0]     grant,
    input  logic [8*N_PORTS-1:0]   gmii_data_in,
    input  logic [N_PORTS-1:0]     gmii_valid_in,
    input  logic [N_PORTS-1:0]     gmii_error_in,
    input  logic [N_PORTS-1:0]     last_in,
    output logic [7:0]             gmii_data_out,
    output logic                   gmii_valid_out,
    output logic                   gmii_error_out,
    output logic                   last_out,
    output logic                   timeout_flag,
    output logic [1:0]             arb_state_dbg
);

    localparam int PTR_W = $clog2(N_PORTS);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_q, rr_d;
    logic [PTR_W-1:0]   sel_q, sel_d;
    logic [15:0]        wd_q, wd_d;
    logic [7:0]         gap_q, gap_d;
    logic [N_PORTS-1:0] grant_q, grant_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               err_q, err_d;
    logic               last_q, last_d;
    logic               flag_q, flag_d;

    logic               w_pick_valid;
    logic [PTR_W-1:0]   w_pick;
    logic [PTR_W-1:0]   w_idx;
    logic [PTR_W-1:0]   w_rr_next;
    logic [7:0]         w_sel_data;
    logic               w_sel_valid;
    logic               w_sel_err;
    logic               w_sel_last;

    function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_PORTS) s = s - N_PORTS;
        return PTR_W'(s);
    endfunction

    // Scan downward so the lowest offset from rr_q wins.
    always_comb begin
        w_pick_valid = 1'b0;
        w_pick       = '0;
        w_idx        = '0;
        for (int k = N_PORTS - 1; k >= 0; k--) begin
            w_idx = wrap_idx(rr_q, k);
            if (request[w_idx]) begin
                w_pick_valid = 1'b1;
                w_pick       = w_idx;
            end
        end
    end

    assign w_rr_next   = wrap_idx(sel_q, 1);
    assign w_sel_data  = gmii_data_in[{sel_q, 3'b000} +: 8];
    assign w_sel_valid = gmii_valid_in[sel_q];
    assign w_sel_err   = gmii_error_in[sel_q];
    assign w_sel_last  = last_in[sel_q];

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        wd_d    = wd_q;
        gap_d   = gap_q;
        grant_d = '0;
        data_d  = '0;
        valid_d = 1'b0;
        err_d   = 1'b0;
        last_d  = 1'b0;
        flag_d  = flag_q;
        case (state_q)
            S_IDLE: begin
                if (w_pick_valid) begin
                    sel_d   = w_pick;
                    grant_d = {{(N_PORTS-1){1'b0}}, 1'b1} << w_pick;
                    wd_d    = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                data_d  = w_sel_data;
                valid_d = w_sel_valid;
                err_d   = w_sel_err;
                last_d  = w_sel_last;
                if (w_sel_last) begin
                    rr_d    = w_rr_next;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else if (wd_q == 16'(TIMEOUT_CYCLES - 1)) begin
                    // This is the TIMEOUT_CYCLES-th cycle: replace the beat with an abort marker.
                    data_d  = '0;
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    last_d  = 1'b1;
                    flag_d  = 1'b1;
                    rr_d    = w_rr_next;
                    gap_d   = '0;
                    state_d = S_GAP;
                end else begin
                    wd_d = wd_q + 16'd1;
                end
            end
            S_GAP: begin
                if (gap_q == 8'(IFG_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge gmii_clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= '0;
            sel_q   <= '0;
            wd_q    <= '0;
            gap_q   <= '0;
            grant_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            wd_q    <= wd_d;
            gap_q   <= gap_d;
            grant_q <= grant_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            last_q  <= last_d;
            flag_q  <= flag_d;
        end
    end

    assign grant          = grant_q;
    assign gmii_data_out  = data_q;
    assign gmii_valid_out = valid_q;
    assign gmii_error_out = err_q;
    assign last_out       = last_q;
    assign timeout_flag   = flag_q;
    assign arb_state_dbg  = state_q;

endmodule

`default_nettype wire

// File: tb/tb_net_stream_arbiter.sv
// ============================================================================
// Module   : tb_net_stream_arbiter
// Brief    : Directed/randomized self-checking bench for net_stream_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_net_stream_arbiter;

    localparam int N   = 4;
    localparam int IFG = 12;
    localparam int TO  = 4095;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N-1:0]     request;
    logic [N-1:0]     grant;
    logic [8*N-1:0]   gmii_data_in;
    logic [N-1:0]     gmii_valid_in;
    logic [N-1:0]     gmii_error_in;
    logic [N-1:0]     last_in;
    logic [7:0]       gmii_data_out;
    logic             gmii_valid_out;
    logic             gmii_error_out;
    logic             last_out;
    logic             timeout_flag;
    logic [1:0]       arb_state_dbg;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_rr  = 0;
    logic exp_flag = 1'b0;
    int   port;

    always #5 clk = ~clk;

    net_stream_arbiter #(
        .N_PORTS        (N),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .gmii_clk_out   (clk),
        .rst_n          (rst_n),
        .request        (request),
        .grant          (grant),
        .gmii_data_in   (gmii_data_in),
        .gmii_valid_in  (gmii_valid_in),
        .gmii_error_in  (gmii_error_in),
        .last_in        (last_in),
        .gmii_data_out  (gmii_data_out),
        .gmii_valid_out (gmii_valid_out),
        .gmii_error_out (gmii_error_out),
        .last_out       (last_out),
        .timeout_flag   (timeout_flag),
        .arb_state_dbg  (arb_state_dbg)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] out_beat();
        return {21'd0, gmii_data_out, gmii_valid_out, gmii_error_out, last_out};
    endfunction

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] req, input int rr);
        for (int k = 0; k < N; k++) begin
            if (req[(rr + k) % N]) return (rr + k) % N;
        end
        return -1;
    endfunction

    task automatic drive_noise();
        gmii_data_in  = (8*N)'($urandom);
        gmii_valid_in = N'($urandom);
        gmii_error_in = N'($urandom);
        last_in       = N'($urandom);
    endtask

    task automatic frame(input logic [N-1:0] req, input int len, input bit do_last,
                         input int stop_after, output int p);
        int         waited;
        logic [7:0] sd;
        logic       sv, se, sl;
        logic [31:0] exp_b;
        p = pick(req, exp_rr);
        request = req;
        waited = 0;
        while (waited < 20) begin
            drive_noise();
            tick();
            waited++;
            if (grant != '0) break;
        end
        chk("grant_latency", 32'(waited), 1);
        chk("grant", 32'(grant), (p >= 0) ? (32'd1 << p) : 32'd0);
        chk("state_xfer", 32'(arb_state_dbg), 1);
        if (p < 0) return;
        for (int k = 0; k < len; k++) begin
            if (stop_after > 0 && k == stop_after) return;
            drive_noise();
            sd = 8'($urandom);
            sv = ($urandom % 8) != 0;
            se = ($urandom % 16) == 0;
            sl = do_last && (k == len - 1);
            gmii_data_in[8*p +: 8] = sd;
            gmii_valid_in[p]       = sv;
            gmii_error_in[p]       = se;
            last_in[p]             = sl;
            tick();
            if (!sl && k == TO - 1) begin
                exp_b    = {21'd0, 8'h00, 1'b0, 1'b1, 1'b1};
                exp_flag = 1'b1;
            end else begin
                exp_b = {21'd0, sd, sv, se, sl};
            end
            chk("beat", out_beat(), exp_b);
            chk("grant_pulse", 32'(grant), 0);
        end
        exp_rr = (p + 1) % N;
        chk("timeout_flag", 32'(timeout_flag), 32'(exp_flag));
    endtask

    task automatic gap(input int raise_at, input logic [N-1:0] new_req);
        for (int i = 1; i <= IFG; i++) begin
            if (i == raise_at) request = new_req;
            drive_noise();
            tick();
            chk("gap_out", out_beat(), 0);
            chk("gap_grant", 32'(grant), 0);
            chk("gap_state", 32'(arb_state_dbg), (i < IFG) ? 2 : 0);
        end
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_out", out_beat(), 0);
        chk("rst_async_grant", 32'(grant), 0);
        chk("rst_async_state", 32'(arb_state_dbg), 0);
        chk("rst_async_flag", 32'(timeout_flag), 0);
        exp_rr   = 0;
        exp_flag = 1'b0;
        tick();
        tick();
        chk("rst_hold_out", out_beat(), 0);
        #3 rst_n = 1'b1;
    endtask

    initial begin
        rst_n         = 1'b0;
        request       = '0;
        gmii_data_in  = '0;
        gmii_valid_in = '0;
        gmii_error_in = '0;
        last_in       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", out_beat(), 0);
        chk("reset_grant", 32'(grant), 0);
        chk("reset_state", 32'(arb_state_dbg), 0);
        chk("reset_flag", 32'(timeout_flag), 0);
        #3 rst_n = 1'b1;

        // Idle with no requests: noise on the data inputs must not leak out.
        for (int i = 0; i < 4; i++) begin
            drive_noise();
            tick();
            chk("idle_out", out_beat(), 0);
            chk("idle_grant", 32'(grant), 0);
            chk("idle_state", 32'(arb_state_dbg), 0);
        end

        // Single source, 64-beat frame.
        frame(4'b0100, 64, 1'b1, 0, port);
        request = '0;
        gap(0, '0);

        // last_in on the very cycle the watchdog would expire: normal end.
        frame(4'b0001, TO, 1'b1, 0, port);
        request = '0;
        gap(0, '0);

        // All ports requesting continuously from a fresh reset.
        do_reset();
        request = 4'b1111;
        for (int f = 0; f < 5; f++) begin
            frame(4'b1111, 1 + int'($urandom % 8), 1'b1, 0, port);
            if (f == 4) request = '0;
            gap(0, '0);
        end

        // Request from port 3 arrives mid-gap and must wait for the gap to end.
        frame(4'b0001, 5, 1'b1, 0, port);
        request = '0;
        gap(4, 4'b1000);
        frame(4'b1000, 3, 1'b1, 0, port);
        request = '0;
        gap(0, '0);

        // Watchdog abort, then arbitration moves past the aborted port.
        frame(4'b0010, TO, 1'b0, 0, port);
        request = 4'b0110;
        gap(0, '0);
        frame(4'b0110, 4, 1'b1, 0, port);
        request = '0;
        gap(0, '0);

        // Reset in the middle of a port-2 frame.
        frame(4'b0100, 40, 1'b1, 10, port);
        request = 4'b0101;
        do_reset();
        frame(4'b0101, 6, 1'b1, 0, port);
        request = '0;
        gap(0, '0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
